cxs_rxflit_mgmt: RTL
====================

// Module: cxs_rxflit_mgmt
// PURPOSE
//  Receive-side flit management for the CXS bridge. Tracks the 15-entry RX flit buffer.
//  Grants link credits only for buffer slots that are free, and writes each arriving flit into the next slot.
//  Sets a per-slot ownership bit that hands the flit to software through the register interface.
//  Software clears a slot's ownership to free it, which lets that slot be re-credited.
// PARAMETERS
//  NUM_ENTRIES  15  flit buffer slots; also the maximum number of outstanding CXS credits
//  ADDR_W       4   slot index width
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            reset: synchronous, active-low; clock clk
//  link_up        in   1            CXS link active
//  rx_flit_valid  in   1            flit received this cycle (consumes one credit)
//  credit_rtn     in   1            peer returned an unused credit this cycle (consumes one credit, no data)
//  own_clear      in   NUM_ENTRIES  one-cycle pulses from software; bit k releases slot k
//  write_en       out  1            buffer write strobe
//  write_addr     out  ADDR_W       buffer slot being written
//  ownership      out  NUM_ENTRIES  bit k=1: slot k holds a flit owned by software
//  credit_gnt     out  1            one-cycle credit grant to the link
//  credits_out    out  ADDR_W       credits granted but not yet consumed (0..15)
//  overflow_err   out  1            sticky: flit or credit_rtn arrived with credits_out==0
// BEHAVIOUR
//  Reset values: all outputs 0; wr_ptr=0, gnt_ptr=0; FSM state IDLE.
//  FSM states:
//   IDLE   no grants. Moves to GRANT when link_up=1.
//   GRANT  issues credits per the grant rule. If link_up falls: go to DRAIN if credits_out>0, else IDLE.
//   DRAIN  no grants; keeps consuming flits and credit_rtn. Moves to IDLE when credits_out==0.
//  Grant rule, evaluated on registered state:
//   - Condition: state==GRANT & credits_out<NUM_ENTRIES & ownership[gnt_ptr]==0.
//   - When true, the next cycle has credit_gnt=1; gnt_ptr and credits_out both increment.
//   - At most one grant per cycle. Slots are credited strictly in order.
//  Consume event (rx_flit_valid or credit_rtn with credits_out>0):
//   - credits_out decrements on the next edge; wr_ptr advances.
//   - For rx_flit_valid only, on the next edge: write_en=1, write_addr=wr_ptr, ownership[wr_ptr]<=1.
//   - ownership is set on the same edge as the credits_out decrement. A slot being written therefore
//     can never pass the grant rule.
//   - rx_flit_valid and credit_rtn in the same cycle: flit takes priority; credit_rtn is flagged
//     as overflow_err and ignored.
//  Consume event with credits_out==0: event dropped, overflow_err<=1 (cleared only by reset),
//   no pointer change.
//  Grant and consume in the same cycle: credits_out unchanged; both pointers advance.
//  Pointer wrap: wr_ptr and gnt_ptr count 0..NUM_ENTRIES-1, then return to 0 (14 -> 0).
//   Invariant: gnt_ptr == (wr_ptr + credits_out) mod NUM_ENTRIES.
//  own_clear[k]: clears ownership[k] next edge if it is set; ignored if it is already 0.
//   Set and clear cannot target the same slot in one cycle, because the written slot is unowned.
//  Latency: grant-to-flit has no minimum. Flit in (cycle N) -> write_en and ownership at N+1.
//   own_clear (cycle N) -> re-grant of that slot at N+2 at the earliest, and only once gnt_ptr reaches it.
//  Reset mid-operation: all state returns to reset values; buffered flits and ownership are lost.
// STRUCTURE
//  Shared package cxs_bridge_pkg:
//   - NUM_ENTRIES and ADDR_W constants
//   - FSM state localparams
//   - ptr_inc(ptr) wrap function, shared with the TX flit management
//  Single flat module; no sub-module.
// TESTING
//  1. Reset, link_up=1 -> 15 consecutive credit_gnt pulses, credits_out=15, gnt_ptr=0, no 16th grant.
//  2. 15 flits back-to-back -> write_addr 0..14, ownership=15'h7FFF, credits_out=0, no grants issued.
//  3. From state 2, own_clear=15'h0004 (slot 2), out of order -> no grant (gnt_ptr=0 still owned).
//     Then own_clear slot 0 -> grant 2 cycles later, gnt_ptr=1.
//  4. credits_out=0, then rx_flit_valid -> overflow_err=1, no write_en, ownership unchanged.
//     overflow_err stays set until reset.
//  5. credits_out=3, drop link_up -> DRAIN; 1 flit + 2 credit_rtn -> one write, wr_ptr+=3, IDLE, credit_gnt=0.
//  6. credits_out=5 mid-stream with grant and flit in the same cycle -> credits_out stays 5.
//     Pointers wrap 14->0 correctly; assert the gnt_ptr invariant every cycle.

Source files
------------

// File: rtl/cxs_bridge_pkg.sv
// cxs_bridge_pkg: shared constants, FSM states and pointer wrap for the CXS bridge flit management
package cxs_bridge_pkg;
  localparam int NUM_ENTRIES = 15;
  localparam int ADDR_W = 4;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
    return ptr == ADDR_W'(NUM_ENTRIES - 1) ? '0 : ptr + 1'b1;
  endfunction
endpackage

// File: rtl/cxs_rxflit_mgmt.sv
// cxs_rxflit_mgmt: RX flit buffer slot tracking, in-order credit granting and software ownership handoff
module cxs_rxflit_mgmt
  import cxs_bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   link_up,
  input  logic                   rx_flit_valid,
  input  logic                   credit_rtn,
  input  logic [NUM_ENTRIES-1:0] own_clear,
  output logic                   write_en,
  output logic [ADDR_W-1:0]      write_addr,
  output logic [NUM_ENTRIES-1:0] ownership,
  output logic                   credit_gnt,
  output logic [ADDR_W-1:0]      credits_out,
  output logic                   overflow_err
);
  state_t state;
  logic [ADDR_W-1:0] wr_ptr, gnt_ptr, credits_next;
  logic grant, consume, wr, bad;
  always_comb begin
    grant = state == GRANT && credits_out < ADDR_W'(NUM_ENTRIES) && !ownership[gnt_ptr];
    consume = (rx_flit_valid || credit_rtn) && credits_out != '0;
    wr = rx_flit_valid && credits_out != '0;
    bad = ((rx_flit_valid || credit_rtn) && credits_out == '0) || (rx_flit_valid && credit_rtn);
    credits_next = credits_out + ADDR_W'(grant) - ADDR_W'(consume);
  end
  // a written slot is never the one being cleared, so set and clear cannot collide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      gnt_ptr <= '0;
      credits_out <= '0;
      ownership <= '0;
      credit_gnt <= 1'b0;
      write_en <= 1'b0;
      write_addr <= '0;
      overflow_err <= 1'b0;
    end else begin
      state <= state == IDLE  ? (link_up ? GRANT : IDLE) :
               state == GRANT ? (link_up ? GRANT : credits_next != '0 ? DRAIN : IDLE) :
                                (credits_out == '0 ? IDLE : DRAIN);
      credits_out <= credits_next;
      credit_gnt <= grant;
      write_en <= wr;
      if (wr) write_addr <= wr_ptr;
      ownership <= (ownership & ~own_clear) | (wr ? NUM_ENTRIES'(1'b1) << wr_ptr : '0);
      if (grant) gnt_ptr <= ptr_inc(gnt_ptr);
      if (consume) wr_ptr <= ptr_inc(wr_ptr);
      if (bad) overflow_err <= 1'b1;
    end
  end
endmodule
